// File: rtl/chord_sample_mixer.sv
// Three-voice sample mixer: collects per-voice samples, forms a saturated sum and presents it once per codec frame.
// Optional build macro MIXER_UNDERRUN_CNT_EN adds an 8-bit saturating underrun_count output.
module chord_sample_mixer #(
    parameter int WIDTH   = 16,
    parameter int SHIFT   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    new_frame,
    input  logic signed [WIDTH-1:0] sample_one,
    input  logic signed [WIDTH-1:0] sample_two,
    input  logic signed [WIDTH-1:0] sample_three,
    input  logic                    ready_one,
    input  logic                    ready_two,
    input  logic                    ready_three,
    output logic                    generate_next_sample,
    output logic signed [WIDTH-1:0] valid_sample,
    output logic                    clipped
`ifdef MIXER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]              underrun_count
`endif
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, SUM} state_t;

    state_t                   state;
    logic [CW-1:0]            timeout_cnt;
    logic [2:0]               captured;
    logic [2:0]               ready_vec;
    logic [2:0]               captured_next;
    logic signed [WIDTH-1:0]  sample_arr [3];
    logic signed [WIDTH+1:0]  voice_ext  [3];
    logic signed [WIDTH-1:0]  pending;
    logic                     pending_clip;
    logic                     pending_valid;
    logic signed [WIDTH+1:0]  sum_full;
    logic signed [WIDTH+1:0]  sum_shifted;
    logic signed [WIDTH-1:0]  sum_sat;
    logic                     sum_clip;

    assign ready_vec     = {ready_three, ready_two, ready_one};
    assign sample_arr[0] = sample_one;
    assign sample_arr[1] = sample_two;
    assign sample_arr[2] = sample_three;
    assign captured_next = captured | ready_vec;

    // Voice registers keep their last captured value so a timed-out collection reuses stale voices.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_voice
            logic signed [WIDTH-1:0] voice_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    voice_reg <= '0;
                end else if (state == COLLECT && ready_vec[gi]) begin
                    voice_reg <= sample_arr[gi];
                end
            end
            assign voice_ext[gi] = {{2{voice_reg[WIDTH-1]}}, voice_reg};
        end
    endgenerate

    always_comb begin
        sum_full    = voice_ext[0] + voice_ext[1] + voice_ext[2];
        sum_shifted = sum_full >>> SHIFT;
        sum_sat     = sum_shifted[WIDTH-1:0];
        sum_clip    = 1'b0;
        if (sum_shifted > SAT_MAX) begin
            sum_sat  = SAT_MAX[WIDTH-1:0];
            sum_clip = 1'b1;
        end else if (sum_shifted < SAT_MIN) begin
            sum_sat  = SAT_MIN[WIDTH-1:0];
            sum_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            timeout_cnt          <= '0;
            captured             <= '0;
            pending              <= '0;
            pending_clip         <= 1'b0;
            pending_valid        <= 1'b0;
            generate_next_sample <= 1'b0;
            valid_sample         <= '0;
            clipped              <= 1'b0;
        end else begin
            generate_next_sample <= new_frame;

            if (new_frame && pending_valid) begin
                valid_sample <= play ? pending : '0;
                clipped      <= play & pending_clip;
            end

            // A sum finishing on a frame edge must survive that frame's consumption.
            if (state == SUM) begin
                pending_valid <= 1'b1;
            end else if (new_frame) begin
                pending_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (generate_next_sample) begin
                        captured    <= '0;
                        timeout_cnt <= '0;
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    captured <= captured_next;
                    if (&captured_next || timeout_cnt == CW'(TIMEOUT)) begin
                        state <= SUM;
                    end else begin
                        timeout_cnt <= timeout_cnt + CW'(1);
                    end
                end
                SUM: begin
                    pending      <= sum_sat;
                    pending_clip <= sum_clip;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIXER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_count <= '0;
        end else if (new_frame && !pending_valid && underrun_count != 8'hFF) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chord_sample_mixer.sv
// Randomized bench for chord_sample_mixer against a frame-level integer model of the mixer.
module tb_chord_sample_mixer;

    localparam int WIDTH   = 16;
    localparam int SHIFT   = 0;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b1;
    logic        new_frame = 1'b0;
    logic [15:0] sample_one = '0, sample_two = '0, sample_three = '0;
    logic        ready_one = 1'b0, ready_two = 1'b0, ready_three = 1'b0;
    logic        generate_next_sample;
    logic [15:0] valid_sample;
    logic        clipped;
`ifdef MIXER_UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    chord_sample_mixer #(.WIDTH(WIDTH), .SHIFT(SHIFT), .TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .new_frame            (new_frame),
        .sample_one           (sample_one),
        .sample_two           (sample_two),
        .sample_three         (sample_three),
        .ready_one            (ready_one),
        .ready_two            (ready_two),
        .ready_three          (ready_three),
        .generate_next_sample (generate_next_sample),
        .valid_sample         (valid_sample),
        .clipped              (clipped)
`ifdef MIXER_UNDERRUN_CNT_EN
        ,
        .underrun_count       (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference model state
    int m_voice [3];
    int m_pend   = 0;
    bit m_pclip  = 0;
    bit m_pv     = 0;
    int m_valid  = 0;
    bit m_clip   = 0;
    int m_und    = 0;
    logic nf_seen;

    always @(posedge clk or negedge reset) begin
        if (!reset) nf_seen <= 1'b0;
        else        nf_seen <= new_frame;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int s16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int rv();
        case ($urandom % 3)
            0:       return s16(int'($urandom));
            1:       return 24576 + int'($urandom % 8192);
            default: return -32768 + int'($urandom % 8192);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_voice[i] = 0;
        m_pend = 0; m_pclip = 0; m_pv = 0;
        m_valid = 0; m_clip = 0; m_und = 0;
    endtask

    task automatic model_sum();
        int s;
        s = (m_voice[0] + m_voice[1] + m_voice[2]) >>> SHIFT;
        m_pclip = 1'b0;
        if (s > 32767)       begin s = 32767;  m_pclip = 1'b1; end
        else if (s < -32768) begin s = -32768; m_pclip = 1'b1; end
        m_pend = s;
        m_pv   = 1'b1;
    endtask

    task automatic model_frame();
        if (m_pv) begin
            m_valid = play ? m_pend : 0;
            m_clip  = play ? m_pclip : 1'b0;
            m_pv    = 1'b0;
        end else if (m_und < 255) begin
            m_und++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        new_frame = 1'b1;
        @(posedge clk);
        #1;
        new_frame = 1'b0;
        model_frame();
    endtask

    task automatic strobe(input int mask, input int a, input int b, input int c);
        ready_one = mask[0]; ready_two = mask[1]; ready_three = mask[2];
        sample_one = a[15:0]; sample_two = b[15:0]; sample_three = c[15:0];
        @(posedge clk);
        #1;
        ready_one = 1'b0; ready_two = 1'b0; ready_three = 1'b0;
        if (mask[0]) m_voice[0] = s16(a);
        if (mask[1]) m_voice[1] = s16(b);
        if (mask[2]) m_voice[2] = s16(c);
    endtask

    task automatic all_ready(input int a, input int b, input int c);
        strobe(7, a, b, c);
        model_sum();
        tick(3);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid_sample", int'($signed(valid_sample)), m_valid);
            chk("clipped", int'(clipped), int'(m_clip));
            chk("generate_next_sample", int'(generate_next_sample), int'(nf_seen));
`ifdef MIXER_UNDERRUN_CNT_EN
            chk("underrun_count", int'(underrun_count), m_und);
`endif
        end
    end

    initial begin
        int und0;
        model_reset();
        tick(3);
        reset = 1'b1;
        check_en = 1'b1;
        tick(1);

        // Reset state and generate_next_sample timing
        chk("t1_valid_reset", int'($signed(valid_sample)), 0);
        chk("t1_clip_reset", int'(clipped), 0);
        chk("t1_gen_reset", int'(generate_next_sample), 0);
        pulse_frame();
        chk("t1_gen_after_frame", int'(generate_next_sample), 1);
        tick(1);
        chk("t1_gen_single", int'(generate_next_sample), 0);
        chk("t1_valid", int'($signed(valid_sample)), 0);

        // Plain mix
        all_ready(100, -50, 25);
        pulse_frame();
        chk("t2_mix", int'($signed(valid_sample)), 75);
        chk("t2_clip", int'(clipped), 0);
        tick(1);

        // Positive and negative saturation
        all_ready(32'h7000, 32'h7000, 32'h7000);
        pulse_frame();
        chk("t3_sat_pos", int'($signed(valid_sample)), 32767);
        chk("t3_clip_pos", int'(clipped), 1);
        tick(1);
        all_ready(s16(32'h9000), s16(32'h9000), s16(32'h9000));
        pulse_frame();
        chk("t3_sat_neg", int'($signed(valid_sample)), -32768);
        chk("t3_clip_neg", int'(clipped), 1);
        tick(1);

        // Timeout with a stale third voice
        all_ready(1, 1, 5);
        pulse_frame();
        chk("t4_pre", int'($signed(valid_sample)), 7);
        tick(1);
        strobe(1, 10, 0, 0);
        strobe(2, 0, 20, 0);
        tick(TIMEOUT + 10);
        model_sum();
        pulse_frame();
        chk("t4_timeout_sum", int'($signed(valid_sample)), 35);
        tick(1);

        // Two underrun frames while collecting
        und0 = m_und;
        tick(2);
        pulse_frame();
        tick(2);
        pulse_frame();
        chk("t5_hold", int'($signed(valid_sample)), 35);
`ifdef MIXER_UNDERRUN_CNT_EN
        chk("t5_underruns", int'(underrun_count) - und0, 2);
`endif
        tick(TIMEOUT + 10);
        model_sum();

        // play=0 mutes, then reset in the middle of a collection
        pulse_frame();
        tick(1);
        all_ready(100, 100, 100);
        play = 1'b0;
        pulse_frame();
        chk("t6_muted", int'($signed(valid_sample)), 0);
        chk("t6_muted_clip", int'(clipped), 0);
        play = 1'b1;
        tick(1);
        all_ready(100, 100, 100);
        pulse_frame();
        chk("t6_played", int'($signed(valid_sample)), 300);
        tick(1);
        strobe(3, 7, 7, 0);
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_reset_valid", int'($signed(valid_sample)), 0);
        chk("t6_reset_clip", int'(clipped), 0);
        chk("t6_reset_gen", int'(generate_next_sample), 0);
`ifdef MIXER_UNDERRUN_CNT_EN
        chk("t6_reset_und", int'(underrun_count), 0);
`endif
        tick(2);
        reset = 1'b1;
        tick(1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int  n;
            int  mask;
            int  flags;
            bit  collide;
            play = ($urandom % 4) != 0;
            pulse_frame();
            tick(1);
            if ($urandom % 4 == 0) begin
                tick(2);
                pulse_frame();
                tick(1);
            end
            collide = ($urandom % 5) == 0;
            n = 1 + int'($urandom % 4);
            flags = 0;
            for (int k = 0; k < n; k++) begin
                mask = int'($urandom % 8);
                if (k < n - 1) mask = mask & 3;
                else if (collide) mask = 7;
                strobe(mask, rv(), rv(), rv());
                flags = flags | mask;
            end
            if (collide) begin
                pulse_frame();
                model_sum();
                tick(TIMEOUT + 10);
            end else if (flags == 7) begin
                model_sum();
                tick(3 + int'($urandom % 5));
            end else begin
                tick(TIMEOUT + 10);
                model_sum();
            end
        end
        pulse_frame();
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
